// File: rtl/share_mst_line_tx.sv
// share_mst_line_tx: packs WPL input words into one LINE_W line and issues
// each line as a single-cycle valid beat, paced by line requests from the
// MAC side. One job of LineCnt_i lines runs per Start_i.
// Optional build macro: SHARE_MST_TX_BSWAP_EN byte-reverses each word before
// it is packed (big-endian weight images).
module share_mst_line_tx #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start_i,
    input  logic [CNT_W-1:0]  LineCnt_i,
    output logic              Busy_o,
    output logic              Done_o,
    input  logic [WORD_W-1:0] WordData_i,
    input  logic              WordValid_i,
    output logic              WordReady_o,
    input  logic              LineReq_i,
    output logic [LINE_W-1:0] ShareMstLine_o,
    output logic              ShareMstValid_o,
    output logic [CNT_W-1:0]  LinesSent_o
);
    localparam int WPL   = LINE_W / WORD_W;
    localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WAIT, S_SEND, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  sent_q, sent_d, sent_inc;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              req_q, req_d;
    logic [LINE_W-1:0] pack_q, pack_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [WORD_W-1:0] word_in;

`ifdef SHARE_MST_TX_BSWAP_EN
    // Reverse byte order of the incoming word before packing
    always_comb begin
        word_in = '0;
        for (int b = 0; b < WORD_W / 8; b++)
            word_in[b*8 +: 8] = WordData_i[(WORD_W/8 - 1 - b)*8 +: 8];
    end
`else
    assign word_in = WordData_i;
`endif

    // Next-state logic: job sequencing, word packing, request merging
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sent_d   = sent_q;
        idx_d    = idx_q;
        req_d    = req_q;
        pack_d   = pack_q;
        line_d   = line_q;
        sent_inc = sent_q + CNT_W'(1);

        // Requests merge into one pending flag while a job is active
        if (state_q != S_IDLE && LineReq_i)
            req_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (Start_i) begin
                    cnt_d   = LineCnt_i;
                    sent_d  = '0;
                    idx_d   = '0;
                    req_d   = 1'b0;
                    state_d = (LineCnt_i == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (WordValid_i) begin
                    for (int k = 0; k < WPL; k++)
                        if (idx_q == IDX_W'(k))
                            pack_d[k*WORD_W +: WORD_W] = word_in;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (req_q || LineReq_i) begin
                    // Capture the packed line so later FILL cannot disturb it
                    line_d  = pack_q;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                sent_d  = sent_inc;
                // The beat consumes the pending request; a new one this cycle wins
                req_d   = LineReq_i;
                state_d = (sent_inc == cnt_q) ? S_DONE : S_FILL;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sent_q  <= '0;
            idx_q   <= '0;
            req_q   <= 1'b0;
            pack_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            pack_q  <= pack_d;
            line_q  <= line_d;
        end
    end

    assign Busy_o          = (state_q != S_IDLE);
    assign Done_o          = (state_q == S_DONE);
    assign WordReady_o     = (state_q == S_FILL);
    assign ShareMstValid_o = (state_q == S_SEND);
    assign ShareMstLine_o  = line_q;
    assign LinesSent_o     = sent_q;

endmodule
